// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants and types for the text-mode character generator
package video_pkg;

    // 256 glyphs x 8 rows, one byte per row (MSB = leftmost pixel)
    localparam int FONT_AW   = 11;
    localparam int FONT_DW   = 8;
    localparam int FONT_ROWS = 8;

    typedef logic [FONT_AW-1:0] font_addr_t;
    typedef logic [FONT_DW-1:0] font_row_t;

    // Glyph row address as the renderer forms it: {symbol code, text row}
    function automatic font_addr_t glyph_addr(input logic [7:0] code, input logic [2:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/video_fontrom_mem.sv
// rtl/video_fontrom_mem.sv - raw simple dual-port array with registered read port
import video_pkg::*;

module video_fontrom_mem #(
    parameter int AW = FONT_AW,
    parameter int DW = FONT_DW
) (
    input  logic          clock,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] wraddress,
    input  logic          wren,
    input  logic [AW-1:0] rdaddress,
    input  logic          rden,
    output logic [DW-1:0] rd_q
);

    // No reset on the array or the read register so the tools map this onto block RAM
    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write port: one byte per edge when enabled
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
    end

    // Read port: old-data on same-address collision, holds when rden is low
    always_ff @(posedge clock) begin
        if (rden) begin
            rd_q <= mem[rdaddress];
        end
    end

endmodule

// File: rtl/video_fontrom.sv
// rtl/video_fontrom.sv - character-generator RAM top; optional VIDEO_FONTROM_WRITE_THROUGH_EN bypass
import video_pkg::*;

module video_fontrom #(
    parameter int AW = FONT_AW,
    parameter int DW = FONT_DW
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] wraddress,
    input  logic          wren,
    input  logic [AW-1:0] rdaddress,
    input  logic          rden,
    output logic [DW-1:0] q
);

    // Both ports are ignored while reset is held
    logic          mem_wren;
    logic          mem_rden;
    logic [DW-1:0] mem_q;
    logic          q_valid;

    assign mem_wren = wren & rst_n;
    assign mem_rden = rden & rst_n;

    video_fontrom_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clock     (clock),
        .data      (data),
        .wraddress (wraddress),
        .wren      (mem_wren),
        .rdaddress (rdaddress),
        .rden      (mem_rden),
        .rd_q      (mem_q)
    );

    // The array read register cannot be reset, so a valid flag masks q to 0
    // from reset until the first enabled read after deassertion
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
        end else if (rden) begin
            q_valid <= 1'b1;
        end
    end

`ifdef VIDEO_FONTROM_WRITE_THROUGH_EN
    logic          byp_hit;
    logic [DW-1:0] byp_data;

    // Capture a same-address collision so q shows the freshly written byte
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else if (rden) begin
            byp_hit  <= wren && (wraddress == rdaddress);
            byp_data <= data;
        end
    end

    // Output select: reset mask, then bypass, then array data
    always_comb begin
        q = '0;
        if (q_valid) begin
            q = byp_hit ? byp_data : mem_q;
        end
    end
`else
    // Output select: reset mask, then array data
    always_comb begin
        q = '0;
        if (q_valid) begin
            q = mem_q;
        end
    end
`endif

endmodule

// File: tb/tb_video_fontrom.sv
// tb/tb_video_fontrom.sv - directed self-checking bench for video_fontrom
module tb_video_fontrom;

    logic        clock;
    logic        rst_n;
    logic [7:0]  data;
    logic [10:0] wraddress;
    logic        wren;
    logic [10:0] rdaddress;
    logic        rden;
    logic [7:0]  q;

    int errors = 0;
    int checks = 0;

    video_fontrom dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; return 1 time unit after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_byte(input logic [10:0] a, input logic [7:0] d);
        wraddress = a;
        data      = d;
        wren      = 1'b1;
        tick();
        wren      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0;
        data = '0; wraddress = '0; rdaddress = '0;
        tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_initial q=%h expected=%h", q, 8'h00); end
        rst_n = 1'b1;
        tick();
        write_byte(11'h001, 8'hA5);
        rdaddress = 11'h001; rden = 1'b1;
        tick();
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL reset_preload q=%h expected=%h", q, 8'hA5); end
        // assert reset between edges while a read is still being requested
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_async q=%h expected=%h", q, 8'h00); end
        tick();
        tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_held q=%h expected=%h", q, 8'h00); end
        rden = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_no_rden q=%h expected=%h", q, 8'h00); end
        rden = 1'b1;
        tick();
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL reset_first_read q=%h expected=%h", q, 8'hA5); end
        rden = 1'b0;
    endtask

    task automatic test_basic();
        write_byte(11'h123, 8'h3C);
        rdaddress = 11'h123; rden = 1'b1;
        #2;
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL basic_not_early q=%h expected=%h", q, 8'hA5); end
        tick();
        checks++;
        if (q !== 8'h3C) begin errors++; $display("FAIL basic_read q=%h expected=%h", q, 8'h3C); end
    endtask

    task automatic test_hold();
        rden = 1'b0;
        rdaddress = 11'h000;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (q !== 8'h3C) begin errors++; $display("FAIL hold_cycle%0d q=%h expected=%h", i, q, 8'h3C); end
        end
    endtask

    task automatic test_boundary();
        write_byte(11'h7FF, 8'h81);
        write_byte(11'h000, 8'h7E);
        rden = 1'b1;
        rdaddress = 11'h7FF;
        tick();
        checks++;
        if (q !== 8'h81) begin errors++; $display("FAIL boundary_7ff q=%h expected=%h", q, 8'h81); end
        rdaddress = 11'h000;
        tick();
        checks++;
        if (q !== 8'h7E) begin errors++; $display("FAIL boundary_000 q=%h expected=%h", q, 8'h7E); end
        rden = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] exp_coll;
`ifdef VIDEO_FONTROM_WRITE_THROUGH_EN
        exp_coll = 8'h22;
`else
        exp_coll = 8'h11;
`endif
        write_byte(11'h050, 8'h11);
        wraddress = 11'h050; data = 8'h22; wren = 1'b1;
        rdaddress = 11'h050; rden = 1'b1;
        tick();
        wren = 1'b0;
        checks++;
        if (q !== exp_coll) begin errors++; $display("FAIL collision_same_edge q=%h expected=%h", q, exp_coll); end
        tick();
        checks++;
        if (q !== 8'h22) begin errors++; $display("FAIL collision_followup q=%h expected=%h", q, 8'h22); end
        rden = 1'b0;
    endtask

    task automatic test_independent();
        write_byte(11'h020, 8'h55);
        write_byte(11'h010, 8'h00);
        wraddress = 11'h010; data = 8'hFF; wren = 1'b1;
        rdaddress = 11'h020; rden = 1'b1;
        tick();
        wren = 1'b0;
        checks++;
        if (q !== 8'h55) begin errors++; $display("FAIL indep_read q=%h expected=%h", q, 8'h55); end
        rdaddress = 11'h010;
        tick();
        checks++;
        if (q !== 8'hFF) begin errors++; $display("FAIL indep_write q=%h expected=%h", q, 8'hFF); end
        rden = 1'b0;
    endtask

    task automatic test_back_to_back();
        write_byte(11'h3F8, 8'h18);
        write_byte(11'h3F9, 8'h24);
        write_byte(11'h3FA, 8'h42);
        rden = 1'b1;
        rdaddress = 11'h3F8;
        tick();
        checks++;
        if (q !== 8'h18) begin errors++; $display("FAIL b2b_row0 q=%h expected=%h", q, 8'h18); end
        rdaddress = 11'h3F9;
        tick();
        checks++;
        if (q !== 8'h24) begin errors++; $display("FAIL b2b_row1 q=%h expected=%h", q, 8'h24); end
        rdaddress = 11'h3FA;
        tick();
        checks++;
        if (q !== 8'h42) begin errors++; $display("FAIL b2b_row2 q=%h expected=%h", q, 8'h42); end
        rden = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_boundary();
        test_collision();
        test_independent();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
